// File: rtl/memory_apb3_slave_if.sv
// Purpose: APB3 bus bundle between an APB master (decoder/host) and memory_apb3_slave.
// Signals:
//   PADDR   word address            PSEL/PENABLE/PWRITE  APB3 control
//   PWDATA  write data              PSTRB                byte-lane write enables
//   PRDATA  read data               PREADY               transfer complete
//   PSLVERR error, valid with PREADY
interface memory_apb3_slave_if #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 32
);
  logic [ADDR_BITS-1:0]   PADDR;
  logic                   PSEL;
  logic                   PENABLE;
  logic                   PWRITE;
  logic [DATA_BITS-1:0]   PWDATA;
  logic [DATA_BITS/8-1:0] PSTRB;
  logic [DATA_BITS-1:0]   PRDATA;
  logic                   PREADY;
  logic                   PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/memory_apb3_slave.sv
// Purpose: APB3 register-file slave. RW words are written by the host and driven to the fabric;
// RO words are driven by the fabric and read by the host. Programmable wait states, PSLVERR,
// PSTRB byte lanes and one-cycle per-word write/read notification pulses.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   apb                 APB3 slave modport (PADDR..PSLVERR)
//   o_mem_rw_values     RW words, word i at [i*DATA_BITS +: DATA_BITS]
//   o_mem_rw_written    one-cycle pulse: RW word i committed
//   i_mem_ro_values     RO words, same packing
//   o_mem_ro_read       one-cycle pulse: RO word i read (clear-on-read hook)
module memory_apb3_slave #(
  parameter int unsigned          ADDR_BITS    = 8,
  parameter int unsigned          DATA_BITS    = 32,
  parameter int unsigned          RW_SIZE      = 16,
  parameter int unsigned          RO_SIZE      = 16,
  parameter logic [DATA_BITS-1:0] RW_RESET_VAL = '0,
  parameter int unsigned          WAIT_STATES  = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  memory_apb3_slave_if.slave             apb,
  output logic [RW_SIZE*DATA_BITS-1:0]   o_mem_rw_values,
  output logic [RW_SIZE-1:0]             o_mem_rw_written,
  input  logic [RO_SIZE*DATA_BITS-1:0]   i_mem_ro_values,
  output logic [RO_SIZE-1:0]             o_mem_ro_read
);

  localparam int unsigned NBYTES = DATA_BITS / 8;

  typedef enum logic [1:0] {StIdle, StWait, StReady} state_e;

  state_e                 r_state, w_state_d;
  logic [3:0]             r_cnt, w_cnt_d;
  logic [DATA_BITS-1:0]   r_rw [RW_SIZE];
  logic [DATA_BITS-1:0]   r_prdata;
  logic                   r_pready;
  logic                   r_pslverr;
  logic [RW_SIZE-1:0]     r_rw_written;
  logic [RO_SIZE-1:0]     r_ro_read;

  logic [31:0]            w_addr;
  logic [RW_SIZE-1:0]     w_rw_hit;
  logic [RO_SIZE-1:0]     w_ro_hit;
  logic [DATA_BITS-1:0]   w_rdata;
  logic [DATA_BITS-1:0]   w_wmask;
  logic                   w_is_rw, w_is_ro, w_err;
  logic                   w_complete, w_commit_wr, w_commit_rd;

  assign w_addr = 32'(apb.PADDR);

  // Address decode and read mux, evaluated every cycle from the (stable) APB address.
  always_comb begin
    w_rw_hit = '0;
    w_ro_hit = '0;
    w_rdata  = '0;
    for (int unsigned i = 0; i < RW_SIZE; i++) begin
      if (w_addr == i) begin
        w_rw_hit[i] = 1'b1;
        w_rdata     = r_rw[i];
      end
    end
    for (int unsigned j = 0; j < RO_SIZE; j++) begin
      if (w_addr == RW_SIZE + j) begin
        w_ro_hit[j] = 1'b1;
        w_rdata     = i_mem_ro_values[j*DATA_BITS +: DATA_BITS];
      end
    end
  end

  always_comb begin
    w_wmask = '0;
    for (int unsigned k = 0; k < NBYTES; k++) begin
      w_wmask[k*8 +: 8] = {8{apb.PSTRB[k]}};
    end
  end

  assign w_is_rw = |w_rw_hit;
  assign w_is_ro = |w_ro_hit;
  // Error: address outside both windows, or a write aimed at the RO window.
  assign w_err   = !w_is_rw && !(w_is_ro && !apb.PWRITE);

  // FSM next state
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_complete = 1'b0;
    case (r_state)
      StIdle: begin
        if (apb.PSEL && !apb.PENABLE) begin
          w_cnt_d   = 4'(WAIT_STATES);
          w_state_d = (WAIT_STATES == 0) ? StReady : StWait;
        end
      end
      StWait: begin
        if (!apb.PSEL) begin
          w_state_d = StIdle;
        end else if (apb.PENABLE) begin
          w_cnt_d = r_cnt - 4'd1;
          if (r_cnt <= 4'd1) w_state_d = StReady;
        end
      end
      StReady: begin
        // PSEL dropped while PREADY is high counts as an abort, not a completion.
        w_state_d  = StIdle;
        w_complete = apb.PSEL && apb.PENABLE;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_commit_wr = w_complete && apb.PWRITE && w_is_rw && (|apb.PSTRB);
  assign w_commit_rd = w_complete && !apb.PWRITE && w_is_ro;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_prdata     <= '0;
      r_pready     <= 1'b0;
      r_pslverr    <= 1'b0;
      r_rw_written <= '0;
      r_ro_read    <= '0;
      for (int unsigned i = 0; i < RW_SIZE; i++) begin
        r_rw[i] <= RW_RESET_VAL;
      end
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_pready     <= (w_state_d == StReady);
      r_pslverr    <= (w_state_d == StReady) && w_err;
      r_rw_written <= '0;
      r_ro_read    <= '0;
      // Read data (incl. RO snapshot) is captured on the edge entering READY.
      if (w_state_d == StReady && !apb.PWRITE) begin
        r_prdata <= w_err ? '0 : w_rdata;
      end
      if (w_commit_wr) begin
        r_rw_written <= w_rw_hit;
        for (int unsigned i = 0; i < RW_SIZE; i++) begin
          if (w_rw_hit[i]) r_rw[i] <= (r_rw[i] & ~w_wmask) | (apb.PWDATA & w_wmask);
        end
      end
      if (w_commit_rd) begin
        r_ro_read <= w_ro_hit;
      end
    end
  end

  always_comb begin
    o_mem_rw_values = '0;
    for (int unsigned i = 0; i < RW_SIZE; i++) begin
      o_mem_rw_values[i*DATA_BITS +: DATA_BITS] = r_rw[i];
    end
  end

  assign o_mem_rw_written = r_rw_written;
  assign o_mem_ro_read    = r_ro_read;
  assign apb.PRDATA       = r_prdata;
  assign apb.PREADY       = r_pready;
  assign apb.PSLVERR      = r_pslverr;

endmodule
